// File: rtl/snn_pkg.sv
// Shared types and helpers for the rate-coded spike encoder: LFSR geometry,
// FSM state encoding and per-channel seed derivation.
package snn_pkg;

    localparam int PIX_DW_DEF = 8;
    localparam int LFSR_W     = 16;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1 in shift-left Fibonacci form
    localparam int TAP0 = 15;
    localparam int TAP1 = 13;
    localparam int TAP2 = 12;
    localparam int TAP3 = 10;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_REST = 2'd2
    } state_t;

    // Rotate the base seed left by (ch mod 16) so every channel gets a distinct phase
    function automatic logic [LFSR_W-1:0] seed_rot(input logic [LFSR_W-1:0] base,
                                                   input int unsigned ch);
        logic [2*LFSR_W-1:0] dbl;
        dbl = {base, base} << ch[3:0];
        return dbl[2*LFSR_W-1 -: LFSR_W];
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], q[TAP0] ^ q[TAP1] ^ q[TAP2] ^ q[TAP3]};
    endfunction

endpackage

// File: rtl/snn_spike_encoder_if.sv
// Pixel stream into the spike encoder: valid/ready handshake with one
// unsigned intensity per transfer, channels in order 0..INPUTNUM-1.
interface snn_spike_encoder_if #(
    parameter int PIX_DW = 8
);
    logic              pix_valid;
    logic [PIX_DW-1:0] pix_data;
    logic              pix_ready;

    modport master (output pix_valid, output pix_data, input  pix_ready);
    modport slave  (input  pix_valid, input  pix_data, output pix_ready);
endinterface

// File: rtl/snn_lfsr16.sv
// One 16-bit Fibonacci LFSR with synchronous seed load and step enable.
module snn_lfsr16
    import snn_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_VAL = 16'h0001
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= SEED_VAL;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/snn_spike_encoder.sv
// Rate-coded spike encoder: loads one image of pixels, presents Bernoulli spikes
// for WINDOW enabled steps, then holds silence for REST enabled steps.
module snn_spike_encoder
    import snn_pkg::*;
#(
    parameter int          INPUTNUM = 10,
    parameter int          PIX_DW   = PIX_DW_DEF,
    parameter int          WINDOW   = 350,
    parameter int          REST     = 150,
    parameter logic [15:0] SEED     = 16'hACE1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    snn_spike_encoder_if.slave  pix,
    output logic [INPUTNUM-1:0] spikes,
    output logic                rest_phase,
    output logic                busy,
    output logic                img_done
);

    localparam int CNT_MAX = (WINDOW > REST) ? WINDOW : REST;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (INPUTNUM > 1) ? $clog2(INPUTNUM) : 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [PIX_DW-1:0] pixel  [INPUTNUM];
    logic [LFSR_W-1:0] lfsr_q [INPUTNUM];
    logic [INPUTNUM-1:0] hit;

    logic accept;
    logic last_pix;
    logic lfsr_load;
    logic lfsr_step;

    assign pix.pix_ready = (state == ST_LOAD) & en;
    assign accept        = pix.pix_valid & pix.pix_ready;
    assign last_pix      = (idx == IDX_W'(INPUTNUM - 1));
    // Reseed on the final pixel so every image sees the same pseudo-random sequence
    assign lfsr_load     = accept & last_pix;
    assign lfsr_step     = en & (state == ST_RUN);

    for (genvar g = 0; g < INPUTNUM; g++) begin : g_ch
        snn_lfsr16 #(
            .SEED_VAL (seed_rot(SEED, g))
        ) u_lfsr (
            .clk  (clk),
            .rst  (rst),
            .load (lfsr_load),
            .step (lfsr_step),
            .q    (lfsr_q[g])
        );
        assign hit[g] = (lfsr_q[g][PIX_DW-1:0] < pixel[g]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            cnt        <= '0;
            idx        <= '0;
            spikes     <= '0;
            rest_phase <= 1'b0;
            busy       <= 1'b0;
            img_done   <= 1'b0;
            for (int i = 0; i < INPUTNUM; i++) begin
                pixel[i] <= '0;
            end
        end else begin
            // Spikes and the done pulse are single-step outputs unless re-asserted below
            spikes   <= '0;
            img_done <= 1'b0;
            if (en) begin
                case (state)
                    ST_LOAD: begin
                        if (accept) begin
                            pixel[idx] <= pix.pix_data;
                            if (last_pix) begin
                                idx   <= '0;
                                cnt   <= '0;
                                state <= ST_RUN;
                                busy  <= 1'b1;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                    ST_RUN: begin
                        spikes <= hit;
                        if (cnt == CNT_W'(WINDOW - 1)) begin
                            cnt        <= '0;
                            state      <= ST_REST;
                            rest_phase <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_REST: begin
                        if (cnt == CNT_W'(REST - 1)) begin
                            cnt        <= '0;
                            state      <= ST_LOAD;
                            busy       <= 1'b0;
                            rest_phase <= 1'b0;
                            img_done   <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_LOAD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snn_spike_encoder.sv
// Scoreboard bench for snn_spike_encoder: stimulus queues one expected record per
// image, a monitor accumulates the DUT's spike train and checks it on img_done.
module tb_snn_spike_encoder;

    localparam int          N       = 10;
    localparam int          PW      = 8;
    localparam int          WIN     = 350;
    localparam int          RST_CYC = 150;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          BUDGET  = 3000;

    typedef logic [PW-1:0] img_t [N];
    typedef struct packed {
        logic [N-1:0][15:0] cnt;
        logic [N-1:0]       first;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [N-1:0] spikes;
    logic         rest_phase;
    logic         busy;
    logic         img_done;

    snn_spike_encoder_if #(.PIX_DW(PW)) pix ();

    snn_spike_encoder #(
        .INPUTNUM (N),
        .PIX_DW   (PW),
        .WINDOW   (WIN),
        .REST     (RST_CYC),
        .SEED     (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pix        (pix),
        .spikes     (spikes),
        .rest_phase (rest_phase),
        .busy       (busy),
        .img_done   (img_done)
    );

    always #5 clk = ~clk;

    rec_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   stray  = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: bound expired, expected DUT event", name);
    endtask

    function automatic logic [15:0] m_seed(input int ch);
        logic [15:0] s;
        s = SEED;
        for (int k = 0; k < ch % 16; k++) s = {s[14:0], s[15]};
        return s;
    endfunction

    function automatic rec_t model(input img_t px);
        rec_t        r;
        logic [15:0] q;
        int          c;
        r = '0;
        for (int i = 0; i < N; i++) begin
            q = m_seed(i);
            c = 0;
            for (int t = 0; t < WIN; t++) begin
                if (q[PW-1:0] < px[i]) begin
                    c++;
                    if (t == 0) r.first[i] = 1'b1;
                end
                q = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
            end
            r.cnt[i] = 16'(c);
        end
        return r;
    endfunction

    // Counts from the golden LFSR model; first vector optionally from a hand value
    task automatic push(input img_t px, input logic [N-1:0] first_hand, input bit use_hand);
        rec_t r;
        r = model(px);
        if (use_hand) r.first = first_hand;
        exp_q.push_back(r);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        bit           e_s, r_s, busy_pre, rp_pre, in_img;
        int           nvec, busy_cyc, rest_cyc, rest_nz, viol, img_no;
        int           acc [N];
        logic [N-1:0] first_v;
        rec_t         r;
        in_img = 0;
        img_no = 0;
        nvec = 0; busy_cyc = 0; rest_cyc = 0; rest_nz = 0; viol = 0;
        first_v = '0;
        for (int i = 0; i < N; i++) acc[i] = 0;
        forever begin
            @(posedge clk);
            e_s      = en;
            r_s      = rst;
            busy_pre = busy;
            rp_pre   = rest_phase;
            #1;
            if (r_s) begin
                in_img = 0;
                continue;
            end
            if (!in_img) begin
                if (spikes != '0 || img_done) stray++;
                if (busy) begin
                    in_img = 1;
                    nvec = 0; busy_cyc = 0; rest_cyc = 0; rest_nz = 0; viol = 0;
                    first_v = '0;
                    for (int i = 0; i < N; i++) acc[i] = 0;
                end
            end else begin
                if (busy && pix.pix_ready) viol++;
                if (!e_s) begin
                    if (spikes != '0 || busy != busy_pre || rest_phase != rp_pre || img_done) viol++;
                end else begin
                    nvec++;
                    if (busy_pre) busy_cyc++;
                    if (rp_pre) rest_cyc++;
                    if (nvec == 1) first_v = spikes;
                    if (nvec <= WIN) begin
                        for (int i = 0; i < N; i++) acc[i] += int'(spikes[i]);
                    end else if (spikes != '0) begin
                        rest_nz++;
                    end
                    if (img_done) begin
                        in_img = 0;
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            $display("FAIL img%0d_rec: got img_done, expected no image pending", img_no);
                        end else begin
                            r = exp_q.pop_front();
                            for (int i = 0; i < N; i++)
                                chk($sformatf("img%0d_cnt%0d", img_no, i), acc[i], r.cnt[i]);
                            chk($sformatf("img%0d_first", img_no), first_v, r.first);
                            chk($sformatf("img%0d_steps", img_no), nvec, WIN + RST_CYC);
                            chk($sformatf("img%0d_busy_cyc", img_no), busy_cyc, WIN + RST_CYC);
                            chk($sformatf("img%0d_rest_cyc", img_no), rest_cyc, RST_CYC);
                            chk($sformatf("img%0d_rest_spikes", img_no), rest_nz, 0);
                            chk($sformatf("img%0d_viol", img_no), viol, 0);
                        end
                        img_no++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset(input string tag);
        chk({tag, "_spikes"}, spikes, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rest"}, rest_phase, 0);
        chk({tag, "_done"}, img_done, 0);
        chk({tag, "_ready"}, pix.pix_ready, 1);
    endtask

    task automatic load_image(input img_t px, input int n, input bit keep);
        int w;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            w = 0;
            while (!pix.pix_ready && w < BUDGET) begin
                @(negedge clk);
                w++;
            end
            if (w >= BUDGET) fail_now("load_ready");
            pix.pix_valid = 1'b1;
            pix.pix_data  = px[i];
        end
        @(negedge clk);
        if (keep) pix.pix_data = PW'($urandom);
        else      pix.pix_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit junk);
        int w;
        w = 0;
        while (busy && w < BUDGET) begin
            if (junk) begin
                pix.pix_valid = 1'b1;
                pix.pix_data  = PW'($urandom);
            end else begin
                pix.pix_valid = 1'b0;
            end
            @(negedge clk);
            w++;
        end
        pix.pix_valid = 1'b0;
        if (w >= BUDGET) fail_now("wait_idle");
    endtask

    task automatic rst_pulse();
        pix.pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stimulus
        img_t         im;
        img_t         ramp;
        logic [N-1:0] pat;
        pix.pix_valid = 1'b0;
        pix.pix_data  = '0;
        en  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset("por");

        for (int i = 0; i < N; i++) ramp[i] = PW'(i * 28);

        // all-zero image, valid held high throughout
        for (int i = 0; i < N; i++) im[i] = '0;
        push(im, '0, 1'b1);
        load_image(im, N, 1'b1);
        chk("ready_after_load", pix.pix_ready, 0);
        wait_idle(1'b1);

        // 0xE1 < 226 spikes, 0xC3 is not < 195
        im[0] = 8'd226;
        im[1] = 8'd195;
        push(im, 10'b00_0000_0001, 1'b1);
        load_image(im, N, 1'b0);
        wait_idle(1'b0);

        im[0] = 8'd225;
        push(im, 10'b00_0000_0000, 1'b1);
        load_image(im, N, 1'b0);
        wait_idle(1'b0);

        // saturated image; junk offered during RUN/REST
        for (int i = 0; i < N; i++) im[i] = 8'hFF;
        push(im, 10'h3FF, 1'b1);
        load_image(im, N, 1'b0);
        wait_idle(1'b1);

        // channel-order check after junk traffic
        pat = 10'b10_1100_1101;
        for (int i = 0; i < N; i++) im[i] = pat[i] ? 8'hFF : 8'h00;
        push(im, pat, 1'b1);
        load_image(im, N, 1'b0);
        wait_idle(1'b0);

        // 20-cycle enable gap mid-RUN
        push(ramp, '0, 1'b0);
        load_image(ramp, N, 1'b0);
        repeat (100) @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b1;
        wait_idle(1'b0);

        // reset after five pixels, then a fresh load must land in channels 0..9
        for (int i = 0; i < N; i++) im[i] = 8'hFF;
        load_image(im, 5, 1'b0);
        rst_pulse();
        check_reset("mid_load");
        pat = 10'b01_0110_0000;
        for (int i = 0; i < N; i++) im[i] = pat[i] ? 8'hFF : 8'h00;
        push(im, pat, 1'b1);
        load_image(im, N, 1'b0);
        wait_idle(1'b0);

        // reset around RUN step 100, then the sequence must restart from the seeds
        load_image(ramp, N, 1'b0);
        repeat (100) @(negedge clk);
        rst_pulse();
        check_reset("mid_run");
        push(ramp, '0, 1'b0);
        load_image(ramp, N, 1'b0);
        wait_idle(1'b0);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("stray_outputs", stray, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/snn_spike_encoder.md
Name: snn_spike_encoder

Overview:
Rate-coded input stage directly upstream of the SNN core. Accepts one image of INPUTNUM pixel intensities over a valid/ready stream, then drives a registered spike vector for WINDOW enabled time steps. A pseudo-random comparison per input makes spike probability ≈ pixel/2^PIX_DW. A REST phase with all-zero spikes follows so the excitatory neurons can decay before the next image.

Parameters:
INPUTNUM, 10, number of input channels (pixels / spike lines)
PIX_DW, 8, pixel intensity width; must be ≤ 16
WINDOW, 350, enabled time steps of spike presentation per image
REST, 150, enabled time steps of silence after presentation
SEED, 16'hACE1, base LFSR seed; must be nonzero

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  global time-step enable; low freezes all state
pix_valid  in  1  pixel word offered
pix_data  in  PIX_DW  unsigned intensity, channel order 0..INPUTNUM-1
pix_ready  out  1  block accepts a pixel this cycle
spikes  out  INPUTNUM  registered spike vector, bit i feeds input i of the SNN core
rest_phase  out  1  high while in REST
busy  out  1  high in RUN or REST
img_done  out  1  one-cycle pulse at end of REST

Behaviour:
- Clock/reset: single clock clk; reset rst synchronous, active-high. All state updates on posedge clk.
- Reset values: state=LOAD, pixel regs=0, load index=0, step counter=0, every LFSR_i=seed_i, spikes=0, rest_phase=0, busy=0, img_done=0.
- Seeds: seed_i = SEED rotated left by (i mod 16). With the default SEED, seed_0=16'hACE1 and seed_1=16'h59C3.
- LFSR: one 16-bit Fibonacci LFSR per channel, polynomial x^16+x^14+x^13+x^11+1. Next value = {q[14:0], q[15]^q[13]^q[12]^q[10]}.
- pix_ready = (state==LOAD) & en. This is combinational and must never be high outside LOAD.
- LOAD:
  - A transfer occurs on pix_valid & pix_ready. pixel[idx] <= pix_data, and idx increments.
  - pix_valid while pix_ready is low is ignored; no data is latched.
  - On acceptance of pixel INPUTNUM-1: idx <= 0, every LFSR_i <= seed_i, counter <= 0, state <= RUN, busy <= 1.
- RUN (each cycle with en=1):
  - spikes[i] <= (LFSR_i[PIX_DW-1:0] < pixel[i]), an unsigned compare.
  - Every LFSR advances one step; counter increments.
  - When counter reaches WINDOW-1: counter <= 0, state <= REST, rest_phase <= 1.
  - Spikes are therefore nonzero-capable for exactly WINDOW enabled cycles, beginning one cycle after the RUN entry edge.
  - The first vector uses the seed values.
- REST (each cycle with en=1):
  - spikes <= 0; counter increments.
  - When counter reaches REST-1: state <= LOAD, busy <= 0, rest_phase <= 0, img_done <= 1 for one cycle.
- Outside RUN, spikes is registered 0.
- en=0:
  - State, counter, LFSRs, pixel regs and idx all hold.
  - spikes <= 0.
  - img_done <= 0, so the pulse is never stretched.
- Boundary cases:
  - pixel=0: never spikes.
  - pixel=2^PIX_DW-1: spikes unless the LFSR low bits are all ones.
  - Reset mid-RUN or mid-LOAD: partial image discarded; returns to LOAD with idx=0.
  - Counter width: clog2(max(WINDOW,REST)).

Decomposition:
- Shared package snn_pkg:
  - PIX_DW default
  - LFSR width 16 and its tap constants
  - state enum {LOAD, RUN, REST}
  - seed rotation function
- One natural sub-module: snn_lfsr16, a single LFSR with seed-load, step-enable and q output, instantiated INPUTNUM times in a generate loop.
- The FSM, counter, pixel registers and comparators live in the top level.

Test Plan:
- Reset, then load 10 pixels of 0 with pix_valid held high: pix_ready is low after the 10th transfer, busy=1 for exactly 500 enabled cycles, spikes==0 throughout, single img_done pulse.
- pixel[0]=226, pixel[1]=195, rest 0: first RUN spike vector has bit0=1 (0xE1<226) and bit1=0 (0xC3=195 is not <195). Repeating with pixel[0]=225 gives bit0=0.
- All pixels 255, WINDOW=350: per-channel spike count over RUN equals the golden LFSR model count exactly; REST shows zero spikes; rest_phase is high for 150 enabled cycles.
- Toggle en low for 20 cycles mid-RUN: spikes=0 and all state frozen during the gap. The resumed spike sequence equals the uninterrupted model; total RUN length is still 350 enabled cycles.
- Assert rst after 5 pixels loaded, and again at RUN step 100: all outputs at reset values next cycle. A fresh 10-pixel load works, and the LFSR sequence restarts from the seeds.
- pix_valid asserted during RUN/REST with changing data: no latching, pix_ready stays 0, and the next image loads correctly into channels 0..9.
